// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Purpose  : Blocking write-back / write-allocate controller for a direct-mapped
//            cache array, with block-wide req/ready main-memory handshake.
// Options  : CACHE_CTRL_STATS_EN adds stat_hits / stat_misses counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 256,
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 11,
  parameter int TAG_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [BLOCK_SIZE-1:0] cache_data_write,
  output logic                  cache_dirty_write,
  output logic                  cache_write_en,
  input  logic [BLOCK_SIZE-1:0] cache_data_read,
  input  logic                  cache_dirty_read,
  input  logic                  cache_hit,
  input  logic [TAG_WIDTH-1:0]  cache_replace_tag,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]           stat_hits,
  output logic [15:0]           stat_misses
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_ALLOC     = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [BLOCK_SIZE-1:0]   r_victim;
  logic [ADDR_WIDTH-1:0]   r_wb_addr;
  logic [BLOCK_SIZE-1:0]   r_fill;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic [BLOCK_SIZE-1:0]   w_hit_line;
  logic [BLOCK_SIZE-1:0]   w_alloc_line;
  logic [ADDR_WIDTH-1:0]   w_fill_addr;

  assign cache_addr  = r_addr;
  assign mem_wdata   = r_victim;
  assign w_off       = r_addr[OFFSET_WIDTH-1:0];
  assign w_fill_addr = {r_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  // Store-merged versions of the resident line and of the freshly filled line
  always_comb begin
    w_hit_line   = cache_data_read;
    w_hit_line[w_off*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    w_alloc_line = r_fill;
    if (r_we) begin
      w_alloc_line[w_off*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_victim  <= '0;
      r_wb_addr <= '0;
      r_fill    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_req) begin
        r_addr  <= cpu_addr;
        r_we    <= cpu_we;
        r_wdata <= cpu_wdata;
      end
      if (r_state == S_LOOKUP && !cache_hit && cache_dirty_read) begin
        r_victim  <= cache_data_read;
        r_wb_addr <= {cache_replace_tag, r_addr[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
      end
      if (r_state == S_FILL && mem_ready) begin
        r_fill <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next            = r_state;
    cpu_rdata         = '0;
    cpu_ready         = 1'b0;
    cache_data_write  = '0;
    cache_dirty_write = 1'b0;
    cache_write_en    = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          cpu_ready = 1'b1;
          w_next    = S_IDLE;
          if (r_we) begin
            cache_write_en    = 1'b1;
            cache_data_write  = w_hit_line;
            cache_dirty_write = 1'b1;
          end else begin
            cpu_rdata = cache_data_read[w_off*DATA_WIDTH +: DATA_WIDTH];
          end
        end else if (cache_dirty_read) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_FILL;
        end
      end
      S_WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_wb_addr;
        if (mem_ready) w_next = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = w_fill_addr;
        if (mem_ready) w_next = S_ALLOC;
      end
      S_ALLOC: begin
        cache_write_en    = 1'b1;
        cache_data_write  = w_alloc_line;
        cache_dirty_write = r_we;
        cpu_rdata         = r_fill[w_off*DATA_WIDTH +: DATA_WIDTH];
        cpu_ready         = 1'b1;
        w_next            = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // One count per LOOKUP outcome; counters wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (cache_hit) stat_hits <= stat_hits + 16'd1;
      else           stat_misses <= stat_misses + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// Testbench for cache_controller: behavioural cache array and main memory,
// expected transactions queued by the stimulus and checked by monitors.
module tb_cache_controller;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [27:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic [27:0]   cache_addr;
  logic [255:0]  cache_data_write;
  logic          cache_dirty_write;
  logic          cache_write_en;
  logic [255:0]  cache_data_read;
  logic          cache_dirty_read;
  logic          cache_hit;
  logic [13:0]   cache_replace_tag;
  logic          mem_req;
  logic          mem_we;
  logic [27:0]   mem_addr;
  logic [255:0]  mem_wdata;
  logic [255:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cache_addr(cache_addr), .cache_data_write(cache_data_write),
    .cache_dirty_write(cache_dirty_write), .cache_write_en(cache_write_en),
    .cache_data_read(cache_data_read), .cache_dirty_read(cache_dirty_read),
    .cache_hit(cache_hit), .cache_replace_tag(cache_replace_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mem_tx = 0;

  typedef struct { logic we; logic [27:0] addr; logic [255:0] wdata; } mem_t;
  typedef struct { logic chk; logic [31:0] rdata; } cpu_t;
  typedef struct { logic [255:0] data; logic dirty; } wr_t;
  mem_t q_mem[$];
  cpu_t q_cpu[$];
  wr_t  q_wr[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Main-memory line contents: every word encodes its own address
  function automatic logic [255:0] fill(input logic [27:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {4'h5, a[27:3], 3'(w)};
    return l;
  endfunction

  function automatic logic [255:0] put(input logic [255:0] l, input int w, input logic [31:0] d);
    logic [255:0] r;
    r = l;
    r[w*32 +: 32] = d;
    return r;
  endfunction

  // Behavioural direct-mapped array: combinational read, negedge write
  logic [255:0] c_data [2048];
  logic [13:0]  c_tag  [2048];
  logic         c_val  [2048];
  logic         c_dirty[2048];
  initial for (int i = 0; i < 2048; i++) begin
    c_data[i] = '0; c_tag[i] = '0; c_val[i] = 1'b0; c_dirty[i] = 1'b0;
  end
  assign cache_data_read   = c_data[cache_addr[13:3]];
  assign cache_dirty_read  = c_dirty[cache_addr[13:3]];
  assign cache_replace_tag = c_tag[cache_addr[13:3]];
  assign cache_hit         = c_val[cache_addr[13:3]] && (c_tag[cache_addr[13:3]] == cache_addr[27:14]);
  always @(negedge clk) if (cache_write_en) begin
    c_data[cache_addr[13:3]]  = cache_data_write;
    c_dirty[cache_addr[13:3]] = cache_dirty_write;
    c_tag[cache_addr[13:3]]   = cache_addr[27:14];
    c_val[cache_addr[13:3]]   = 1'b1;
  end

  // Main memory responder and transaction checker
  initial begin : mem_model
    bit busy;
    int cnt;
    mem_t e;
    busy = 0; cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        busy = 0; cnt = 0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1; cnt = 0; mem_tx++;
          if (q_mem.size() == 0) begin
            chk("unexpected_mem_req", {227'd0, mem_addr, mem_we}, '0);
          end else begin
            e = q_mem.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          end
        end
        cnt++;
        if (cnt == 3) begin
          mem_ready = 1'b1;
          mem_rdata = fill(mem_addr);
          busy = 0;
        end
      end
    end
  end

  // CPU response monitor
  initial begin : cpu_mon
    cpu_t e;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (q_cpu.size() == 0) chk("unexpected_cpu_ready", 1, 0);
        else begin
          e = q_cpu.pop_front();
          if (e.chk) chk("cpu_rdata", cpu_rdata, e.rdata);
        end
      end
    end
  end

  // Array write monitor
  initial begin : wr_mon
    wr_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cache_write_en) begin
        chk("write_en_back_to_back", prev, 1'b0);
        if (q_wr.size() == 0) chk("unexpected_write_en", 1, 0);
        else begin
          e = q_wr.pop_front();
          chk("cache_data_write", cache_data_write, e.data);
          chk("cache_dirty_write", cache_dirty_write, e.dirty);
        end
      end
      prev = cache_write_en;
    end
  end

  task automatic cpu_op(input logic we, input logic [27:0] a, input logic [31:0] d, input int exp_lat);
    int n;
    bit done;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    n = 0; done = 0;
    while (!done && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (cpu_ready) done = 1;
    end
    cpu_req = 1'b0;
    if (!done) chk("cpu_timeout", 0, 1);
    else if (exp_lat > 0) chk("hit_latency", n, exp_lat);
    @(negedge clk);
  endtask

  initial begin : stim
    int base;
    int n;
    logic [255:0] line;
    #3;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_write_en", cache_write_en, 0);
    chk("rst_cache_addr", cache_addr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: clean load miss
    base = mem_tx;
    q_mem.push_back('{1'b0, 28'h0000010, '0});
    q_wr.push_back('{fill(28'h0000010), 1'b0});
    q_cpu.push_back('{1'b1, 32'h5000_0010});
    cpu_op(1'b0, 28'h0000010, '0, 0);
    chk("t1_mem_tx", mem_tx - base, 1);

    // 2: load hit
    base = mem_tx;
    q_cpu.push_back('{1'b1, 32'h5000_0013});
    cpu_op(1'b0, 28'h0000013, '0, 1);
    chk("t2_mem_tx", mem_tx - base, 0);

    // 3: store hit
    base = mem_tx;
    line = put(fill(28'h0000010), 2, 32'hDEAD_BEEF);
    q_wr.push_back('{line, 1'b1});
    q_cpu.push_back('{1'b0, '0});
    cpu_op(1'b1, 28'h0000012, 32'hDEAD_BEEF, 1);
    chk("t3_mem_tx", mem_tx - base, 0);

    // 4: dirty conflict miss -> writeback then fill
    base = mem_tx;
    q_mem.push_back('{1'b1, 28'h0000010, line});
    q_mem.push_back('{1'b0, 28'h0800010, '0});
    q_wr.push_back('{fill(28'h0800010), 1'b0});
    q_cpu.push_back('{1'b1, 32'h5080_0010});
    cpu_op(1'b0, 28'h0800010, '0, 0);
    chk("t4_mem_tx", mem_tx - base, 2);

    // 5: store miss to clean line
    base = mem_tx;
    q_mem.push_back('{1'b0, 28'h1000020, '0});
    q_wr.push_back('{put(fill(28'h1000020), 5, 32'h1234_5678), 1'b1});
    q_cpu.push_back('{1'b0, '0});
    cpu_op(1'b1, 28'h1000025, 32'h1234_5678, 0);
    chk("t5_mem_tx", mem_tx - base, 1);

    // 6: reset during fill, then the request restarts cleanly
    q_mem.push_back('{1'b0, 28'h0000040, '0});
    cpu_we = 1'b0; cpu_addr = 28'h0000040; cpu_req = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    cpu_req = 1'b0;
    chk("t6_fill_started", mem_req, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_cpu_ready", cpu_ready, 0);
    chk("t6_rst_write_en", cache_write_en, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = mem_tx;
    q_mem.push_back('{1'b0, 28'h0000040, '0});
    q_wr.push_back('{fill(28'h0000040), 1'b0});
    q_cpu.push_back('{1'b1, 32'h5000_0040});
    cpu_op(1'b0, 28'h0000040, '0, 0);
    chk("t6_mem_tx", mem_tx - base, 1);

    repeat (5) @(negedge clk);
    chk("q_mem_empty", q_mem.size(), 0);
    chk("q_cpu_empty", q_cpu.size(), 0);
    chk("q_wr_empty", q_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
